tmu2_qpfill: RTL and testbench
==============================

TMU2_QPFILL -- requirements
Module: tmu2_qpfill

Interface
REQ-001 SHALL have parameter depth, default 11, log2 of the texel-cache RAM capacity in bytes.
REQ-002 SHALL have parameter fml_depth, default 26, log2 of the FML address space in bytes.
REQ-003 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-005 fill_stb  in  1  line fill request; held by requester until fill_ack.
REQ-006 fill_ack  out  1  one-cycle accept pulse.
REQ-007 fill_madr  in  fml_depth  source memory byte address; bits [4:0] ignored.
REQ-008 fill_ladr  in  depth  destination cache byte address; bits [4:0] ignored.
REQ-009 fill_busy  out  1  high from accept through the write cycle.
REQ-010 fill_done  out  1  one-cycle pulse, coincident with we.
REQ-011 fml_adr  out  fml_depth  FML burst address, bits [4:0] zero.
REQ-012 fml_stb  out  1  FML read request.
REQ-013 fml_ack  in  1  FML request accepted.
REQ-014 fml_di  in  64  FML read data beat.
REQ-015 we  out  1  cache line write strobe.
REQ-016 wa  out  depth  cache write byte address, bits [4:0] zero.
REQ-017 wd  out  256  assembled cache line.

Function
REQ-018 SHALL implement FSM IDLE, REQUEST, WAIT, DATA, WRITE.
REQ-019 IDLE: fill_stb=1 -> fill_ack=1 that cycle, latch {fill_madr[fml_depth-1:5],5'b0} and {fill_ladr[depth-1:5],5'b0}, go to REQUEST.
REQ-020 REQUEST: fml_stb=1 and fml_adr=latched address, from the first REQUEST cycle, until the cycle with fml_ack=1 (inclusive); then WAIT.
REQ-021 fml_ack during the first REQUEST cycle SHALL be honoured (single-cycle REQUEST).
REQ-022 With ack in cycle A, beats SHALL be sampled from fml_di at A+2, A+3, A+4, A+5 (constant FML_DATA_LATENCY=2); WAIT lasts 1 cycle, DATA lasts 4 cycles, counted by a 2-bit beat counter.
REQ-023 Beat 0 SHALL land in wd[255:192], beat 1 in [191:128], beat 2 in [127:64], beat 3 in [63:0] (lowest address in MSBs).
REQ-024 WRITE at A+6: we=1, fill_done=1, wa=latched line address, wd=assembled line, for exactly one cycle; then IDLE.
REQ-025 Minimum latency: accept at T, write at T+7.
REQ-026 fill_stb while fill_busy=1 SHALL NOT be acked; it is acked in the first IDLE cycle after WRITE, so back-to-back fills are separated by one IDLE cycle.
REQ-027 fill_busy=1 in REQUEST, WAIT, DATA and WRITE; 0 in IDLE.
REQ-028 wd and wa SHALL hold their values outside WRITE; the cache read ports are valid again from the cycle after we.
REQ-029 Outside their states: fml_stb=0, we=0, fill_ack=0, fill_done=0.

Reset
REQ-030 sys_rst_n=0 SHALL asynchronously force IDLE, with fill_ack=0, fill_busy=0, fill_done=0, fml_stb=0, we=0, fml_adr=0, wa=0, wd=0, and the beat counter at 0.
REQ-031 Reset during any state SHALL abort the fill with no write; beats still arriving after deassertion SHALL be ignored.
REQ-032 Reset deassertion SHALL be synchronised to sys_clk; the first acceptance is possible on the first edge after release.

Structure
REQ-033 The shared tmu2 package SHALL hold the FSM state encodings, FML_DATA_LATENCY=2, FML_BURST_BEATS=4 and LINE_BYTES=32.
REQ-034 One sub-module, tmu2_qpfill_shreg, SHALL hold the 4x64 beat-to-line assembler with load enable and beat index.
REQ-035 Top level: FSM, address latches and counters only; 120-400 lines of RTL total.

Verification
REQ-036 Fill madr=0x0001_2340, ladr=0x640, ack in the first REQUEST cycle, beats 0x1111.., 0x2222.., 0x3333.., 0x4444.. -> fml_adr=0x0001_2340; at T+7 we=1, wa=0x640, wd={1111..,2222..,3333..,4444..}, fill_done=1.
REQ-037 Ack withheld for 5 cycles -> fml_stb held high for 5 cycles with fml_adr stable; we exactly 6 cycles after ack.
REQ-038 fill_stb held high continuously for two fills -> two fill_ack pulses 9 cycles apart, two we pulses, no ack while busy.
REQ-039 sys_rst_n low at A+3 -> all outputs 0 immediately; no we pulse; next fill completes normally.
REQ-040 madr=0x0000_001F, ladr=0x7FF -> fml_adr=0x0, wa=0x7E0.

Source files
------------

// File: rtl/tmu2_qpfill_pkg.sv
// tmu2_qpfill_pkg
// Shared constants and types for the texel-cache line filler.
//   - FSM state encoding (also exported on the top-level debug port)
//   - FML burst geometry: 4 beats of 64 bits, first beat two cycles after ack
//   - cache line geometry: 32 bytes = 256 bits
package tmu2_qpfill_pkg;

  localparam int FML_DATA_LATENCY = 2;
  localparam int FML_BURST_BEATS  = 4;
  localparam int LINE_BYTES       = 32;

  localparam int BEAT_BITS = 64;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int LINE_OFS  = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DATA    = 3'd3,
    ST_WRITE   = 3'd4
  } qpfill_state_t;

endpackage

// File: rtl/tmu2_qpfill_if.sv
// tmu2_qpfill_if
// Bundles the three buses of the line filler:
//   fill side : fill_stb/fill_ack request, fill_madr/fill_ladr addresses,
//               fill_busy, fill_done
//   FML side  : fml_adr/fml_stb request, fml_ack, fml_di read beats
//   cache side: we/wa/wd line write port
// Handshakes: a request (fill_stb, fml_stb) is held with stable address until
// the cycle its acknowledge (fill_ack, fml_ack) is high; that cycle is the
// transfer. fill_ack is a one-cycle pulse. FML read beats carry no valid flag:
// they are defined purely by their fixed cycle offset from fml_ack.
// modport slave is the filler's view, master is the environment's view.
interface tmu2_qpfill_if
  import tmu2_qpfill_pkg::*;
#(
  parameter int depth     = 11,
  parameter int fml_depth = 26
);

  logic                 fill_stb;
  logic                 fill_ack;
  logic [fml_depth-1:0] fill_madr;
  logic [depth-1:0]     fill_ladr;
  logic                 fill_busy;
  logic                 fill_done;

  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_ack;
  logic [BEAT_BITS-1:0] fml_di;

  logic                 we;
  logic [depth-1:0]     wa;
  logic [LINE_BITS-1:0] wd;

  modport slave (
    input  fill_stb, fill_madr, fill_ladr, fml_ack, fml_di,
    output fill_ack, fill_busy, fill_done, fml_adr, fml_stb, we, wa, wd
  );

  modport master (
    output fill_stb, fill_madr, fill_ladr, fml_ack, fml_di,
    input  fill_ack, fill_busy, fill_done, fml_adr, fml_stb, we, wa, wd
  );

endinterface

// File: rtl/tmu2_qpfill_shreg.sv
// tmu2_qpfill_shreg
// Assembles four 64-bit FML beats into one 256-bit cache line.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : a beat is present on i_beat this cycle
//   i_idx      : beat index 0..3 (0 = lowest address = line MSBs)
//   i_beat     : beat data
//   o_line     : assembled line, updated only when the last beat is loaded
// Beats 0..2 are parked in staging registers; the last beat loads the whole
// line register at once, so o_line holds the previous line until the new one
// is complete and then stays stable until the next fill finishes.
module tmu2_qpfill_shreg
  import tmu2_qpfill_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [1:0]           i_idx,
  input  logic [BEAT_BITS-1:0] i_beat,
  output logic [LINE_BITS-1:0] o_line
);

  logic [BEAT_BITS-1:0] r_beat0;
  logic [BEAT_BITS-1:0] r_beat1;
  logic [BEAT_BITS-1:0] r_beat2;
  logic [LINE_BITS-1:0] r_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat0 <= '0;
      r_beat1 <= '0;
      r_beat2 <= '0;
      r_line  <= '0;
    end else if (i_load) begin
      case (i_idx)
        2'd0:    r_beat0 <= i_beat;
        2'd1:    r_beat1 <= i_beat;
        2'd2:    r_beat2 <= i_beat;
        default: r_line  <= {r_beat0, r_beat1, r_beat2, i_beat};
      endcase
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/tmu2_qpfill.sv
// tmu2_qpfill
// Texel-cache line filler: accepts a fill request, issues one 4-beat FML
// burst read for the 32-byte line, assembles the beats and writes the line
// into the cache RAM in a single cycle.
//   sys_clk    : clock
//   sys_rst_n  : asynchronous active-low reset
//   bus        : tmu2_qpfill_if.slave (fill, FML and cache-write buses)
//   dbg_state  : current FSM state
// Timeline with fml_ack in cycle A: WAIT at A+1, beats sampled A+2..A+5,
// WRITE (we/fill_done) at A+6, IDLE at A+7. With ack in the first REQUEST
// cycle, accept at T gives the write at T+7.
module tmu2_qpfill
  import tmu2_qpfill_pkg::*;
#(
  parameter int depth     = 11,
  parameter int fml_depth = 26
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  tmu2_qpfill_if.slave  bus,
  output qpfill_state_t dbg_state
);

  // WAIT lasts FML_DATA_LATENCY-1 cycles, DATA lasts FML_BURST_BEATS cycles;
  // both are counted in the same 2-bit counter.
  localparam logic [1:0] WAIT_LAST = 2'(FML_DATA_LATENCY - 2);
  localparam logic [1:0] BEAT_LAST = 2'(FML_BURST_BEATS - 1);

  qpfill_state_t        r_state;
  logic [1:0]           r_cnt;
  logic [fml_depth-1:0] r_fml_adr;
  logic [depth-1:0]     r_ladr;
  logic [depth-1:0]     r_wa;
  logic                 r_fml_stb;
  logic                 r_busy;
  logic                 r_we;

  logic                 w_accept;
  logic                 w_load;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_unused_lsbs;

  // Accept is combinational so fill_ack lands in the same IDLE cycle as the
  // request; gating with sys_rst_n keeps it low while reset is asserted.
  assign w_accept = (r_state == ST_IDLE) && bus.fill_stb && sys_rst_n;
  assign w_load   = (r_state == ST_DATA);

  // Byte-offset bits inside a line are dropped on purpose.
  assign w_unused_lsbs = ^{bus.fill_madr[LINE_OFS-1:0], bus.fill_ladr[LINE_OFS-1:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_fml_adr <= '0;
      r_ladr    <= '0;
      r_wa      <= '0;
      r_fml_stb <= 1'b0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fml_adr <= {bus.fill_madr[fml_depth-1:LINE_OFS], {LINE_OFS{1'b0}}};
            r_ladr    <= {bus.fill_ladr[depth-1:LINE_OFS], {LINE_OFS{1'b0}}};
            r_fml_stb <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (bus.fml_ack) begin
            r_fml_stb <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_DATA: begin
          // Wraps back to 0 after the last beat, ready for the next fill.
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == BEAT_LAST) begin
            r_we    <= 1'b1;
            r_wa    <= r_ladr;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  tmu2_qpfill_shreg u_shreg (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .i_load (w_load),
    .i_idx  (r_cnt),
    .i_beat (bus.fml_di),
    .o_line (w_line)
  );

  assign bus.fill_ack  = w_accept;
  assign bus.fill_busy = r_busy;
  assign bus.fill_done = r_we;
  assign bus.fml_adr   = r_fml_adr;
  assign bus.fml_stb   = r_fml_stb;
  assign bus.we        = r_we;
  assign bus.wa        = r_wa;
  assign bus.wd        = w_line;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_tmu2_qpfill.sv
module tb_tmu2_qpfill;
  import tmu2_qpfill_pkg::*;

  localparam int DEPTH = 11;
  localparam int FML_DEPTH = 26;
  localparam int W = DEPTH + 256;

  logic          sys_clk;
  logic          sys_rst_n;
  qpfill_state_t dbg_state;

  tmu2_qpfill_if #(.depth(DEPTH), .fml_depth(FML_DEPTH)) bus ();

  tmu2_qpfill #(.depth(DEPTH), .fml_depth(FML_DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_we = 0;
  always @(negedge sys_clk) if (bus.we === 1'b1) n_we <= n_we + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int t_rel = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete fill. Starts and ends at the drive point (posedge + 2).
  task automatic run_fill(input logic [25:0] madr, input logic [10:0] ladr,
                          input int ack_delay, input logic [255:0] line,
                          input bit keep_stb, output int t_acc);
    logic [25:0]  exp_fa;
    logic [10:0]  exp_wa;
    logic [W-1:0] expv;
    int t_ack;
    int t_we;
    exp_fa = madr & ~26'h1F;
    exp_wa = ladr & ~11'h1F;
    bus.fill_stb  = 1'b1;
    bus.fill_madr = madr;
    bus.fill_ladr = ladr;
    exp_q.push_back({exp_wa, line});
    t_acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (bus.fill_ack === 1'b1) begin
        t_acc = cyc;
        break;
      end
      @(posedge sys_clk); #2;
    end
    n_vec++;
    if (t_acc < 0) begin
      n_err++;
      $display("FAIL accept_timeout: fill_ack=%b, wanted 1 within 20 cycles", bus.fill_ack);
      void'(exp_q.pop_back());
      bus.fill_stb = 1'b0;
      @(posedge sys_clk); #2;
      return;
    end
    n_vec++;
    if (bus.fill_busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_at_accept: fill_busy=%b, wanted 0", bus.fill_busy);
    end
    @(posedge sys_clk); #2;
    if (!keep_stb) bus.fill_stb = 1'b0;
    t_ack = -1;
    for (int k = 0; k <= ack_delay; k++) begin
      bus.fml_ack = (k == ack_delay);
      @(negedge sys_clk);
      if (k == ack_delay) t_ack = cyc;
      n_vec++;
      if (bus.fml_stb !== 1'b1 || bus.fml_adr !== exp_fa || bus.fill_busy !== 1'b1 || bus.fill_ack !== 1'b0) begin
        n_err++;
        $display("FAIL request k=%0d: stb=%b adr=%h busy=%b ack=%b, wanted stb=1 adr=%h busy=1 ack=0",
                 k, bus.fml_stb, bus.fml_adr, bus.fill_busy, bus.fill_ack, exp_fa);
      end
      @(posedge sys_clk); #2;
    end
    bus.fml_ack = 1'b0;
    @(negedge sys_clk);
    n_vec++;
    if (bus.fml_stb !== 1'b0 || bus.we !== 1'b0 || bus.fill_ack !== 1'b0 || bus.fill_busy !== 1'b1) begin
      n_err++;
      $display("FAIL wait_cycle: stb=%b we=%b ack=%b busy=%b, wanted 0 0 0 1",
               bus.fml_stb, bus.we, bus.fill_ack, bus.fill_busy);
    end
    @(posedge sys_clk); #2;
    for (int i = 0; i < 4; i++) begin
      bus.fml_di = line[255 - 64*i -: 64];
      @(negedge sys_clk);
      n_vec++;
      if (bus.we !== 1'b0 || bus.fill_ack !== 1'b0 || bus.fml_stb !== 1'b0) begin
        n_err++;
        $display("FAIL data_beat%0d: we=%b ack=%b stb=%b, wanted 0 0 0", i, bus.we, bus.fill_ack, bus.fml_stb);
      end
      @(posedge sys_clk); #2;
    end
    bus.fml_di = {$urandom, $urandom};
    t_we = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (bus.we === 1'b1) begin
        t_we = cyc;
        break;
      end
      @(posedge sys_clk); #2;
    end
    n_vec++;
    if (t_we < 0) begin
      n_err++;
      $display("FAIL write_timeout: we=%b, wanted 1 within 20 cycles", bus.we);
      void'(exp_q.pop_front());
      @(posedge sys_clk); #2;
      return;
    end
    n_vec++;
    if (t_we - t_ack !== 6 || t_we - t_acc !== 7 + ack_delay) begin
      n_err++;
      $display("FAIL write_latency: ack->we=%0d accept->we=%0d, wanted 6 and %0d",
               t_we - t_ack, t_we - t_acc, 7 + ack_delay);
    end
    n_vec++;
    if (bus.fill_done !== 1'b1 || bus.fill_busy !== 1'b1 || bus.fill_ack !== 1'b0) begin
      n_err++;
      $display("FAIL write_flags: done=%b busy=%b ack=%b, wanted 1 1 0", bus.fill_done, bus.fill_busy, bus.fill_ack);
    end
    expv = exp_q.pop_front();
    n_vec++;
    if ({bus.wa, bus.wd} !== expv) begin
      n_err++;
      $display("FAIL write_data: wa=%h wd=%h, wanted wa=%h wd=%h", bus.wa, bus.wd, expv[W-1:256], expv[255:0]);
    end
    @(posedge sys_clk); #2;
  endtask

  task automatic test_reset;
    bus.fill_stb  = 1'b1;
    bus.fill_madr = 26'h0ABCDE0;
    bus.fill_ladr = 11'h100;
    bus.fml_ack   = 1'b0;
    bus.fml_di    = '0;
    sys_rst_n     = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if ({bus.fill_ack, bus.fill_busy, bus.fill_done, bus.fml_stb, bus.we} !== 5'b0 ||
        bus.fml_adr !== 26'h0 || bus.wa !== 11'h0 || bus.wd !== 256'h0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_values: ack=%b busy=%b done=%b stb=%b we=%b adr=%h wa=%h st=%0d, wanted all 0",
               bus.fill_ack, bus.fill_busy, bus.fill_done, bus.fml_stb, bus.we, bus.fml_adr, bus.wa, dbg_state);
    end
    @(posedge sys_clk); #2;
    bus.fill_stb = 1'b0;
    sys_rst_n    = 1'b1;
    t_rel        = cyc;
  endtask

  task automatic test_basic;
    int ta;
    run_fill(26'h0012340, 11'h640, 0,
             {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444},
             1'b0, ta);
    n_vec++;
    if (ta !== t_rel) begin
      n_err++;
      $display("FAIL first_accept: accept cycle=%0d, wanted %0d", ta, t_rel);
    end
    @(negedge sys_clk);
    n_vec++;
    if (bus.we !== 1'b0 || bus.fill_done !== 1'b0 || bus.fill_busy !== 1'b0 || bus.wa !== 11'h640 ||
        bus.wd !== {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444}) begin
      n_err++;
      $display("FAIL after_write: we=%b done=%b busy=%b wa=%h wd=%h, wanted 0 0 0 640 and line held",
               bus.we, bus.fill_done, bus.fill_busy, bus.wa, bus.wd);
    end
    @(posedge sys_clk); #2;
  endtask

  task automatic test_ack_delay;
    int ta;
    run_fill(26'h1A5B3C7, 11'h2C5, 5, rand_line(), 1'b0, ta);
  endtask

  task automatic test_back_to_back;
    int ta1;
    int ta2;
    int we0;
    we0 = n_we;
    run_fill(26'h0345680, 11'h0A0, 1, rand_line(), 1'b1, ta1);
    run_fill(26'h03456A0, 11'h0C0, 1, rand_line(), 1'b0, ta2);
    @(negedge sys_clk);
    n_vec++;
    if (ta2 - ta1 !== 9 || n_we - we0 !== 2) begin
      n_err++;
      $display("FAIL back_to_back: ack gap=%0d writes=%0d, wanted 9 and 2", ta2 - ta1, n_we - we0);
    end
    @(posedge sys_clk); #2;
  endtask

  task automatic test_reset_abort;
    logic [255:0] line;
    int we0;
    int ta;
    line = rand_line();
    we0  = n_we;
    bus.fill_stb  = 1'b1;
    bus.fill_madr = 26'h0045678;
    bus.fill_ladr = 11'h120;
    @(negedge sys_clk);
    n_vec++;
    if (bus.fill_ack !== 1'b1) begin
      n_err++;
      $display("FAIL abort_accept: fill_ack=%b, wanted 1", bus.fill_ack);
    end
    @(posedge sys_clk); #2;
    bus.fill_stb = 1'b0;
    bus.fml_ack  = 1'b1;
    @(posedge sys_clk); #2;
    bus.fml_ack = 1'b0;
    @(posedge sys_clk); #2;
    bus.fml_di = line[255:192];
    @(posedge sys_clk); #2;
    bus.fml_di = line[191:128];
    #1 sys_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.fill_ack, bus.fill_busy, bus.fill_done, bus.fml_stb, bus.we} !== 5'b0 ||
        bus.fml_adr !== 26'h0 || bus.wa !== 11'h0 || bus.wd !== 256'h0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL abort_reset: ack=%b busy=%b done=%b stb=%b we=%b adr=%h wa=%h st=%0d, wanted all 0",
               bus.fill_ack, bus.fill_busy, bus.fill_done, bus.fml_stb, bus.we, bus.fml_adr, bus.wa, dbg_state);
    end
    @(posedge sys_clk); #2;
    bus.fml_di = line[127:64];
    sys_rst_n  = 1'b1;
    @(posedge sys_clk); #2;
    bus.fml_di = line[63:0];
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      n_vec++;
      if (bus.fill_busy !== 1'b0 || bus.fml_stb !== 1'b0 || bus.we !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle%0d: busy=%b stb=%b we=%b, wanted 0 0 0", i, bus.fill_busy, bus.fml_stb, bus.we);
      end
      @(posedge sys_clk); #2;
    end
    n_vec++;
    if (n_we !== we0) begin
      n_err++;
      $display("FAIL abort_no_write: writes=%0d, wanted 0", n_we - we0);
    end
    run_fill(26'h0055540, 11'h3E0, 2, rand_line(), 1'b0, ta);
  endtask

  task automatic test_boundary;
    int ta;
    run_fill(26'h000001F, 11'h7FF, 0, rand_line(), 1'b0, ta);
    run_fill(26'h3FFFFFF, 11'h01F, 1, rand_line(), 1'b0, ta);
  endtask

  task automatic test_random;
    int ta;
    for (int i = 0; i < 5; i++) begin
      run_fill(26'($urandom), 11'($urandom), int'($urandom_range(0, 3)), rand_line(), 1'b0, ta);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_back_to_back();
    test_reset_abort();
    test_boundary();
    test_random();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, wanted 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
